// File: rtl/mul_sequencer.sv
// mul_sequencer: 64-cycle shift-and-add multiplier sequencer (IDLE/RUN/DONE).
// Ports: clk, rst_n (sync, active low); start, opcode[10:0], op_a[63:0], op_b[63:0] in;
//        busy, done, illegal, result[63:0], alu_ctrl[3:0] out.
// Option: define MUL_EARLY_EXIT_EN to leave RUN once the remaining multiplier is zero.
module mul_sequencer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [10:0] opcode,
   input  logic [63:0] op_a,
   input  logic [63:0] op_b,
   output logic        busy,
   output logic        done,
   output logic        illegal,
   output logic [63:0] result,
   output logic [3:0]  alu_ctrl
);

   localparam logic [10:0] OPC_MUL = 11'b10011011000;
   localparam logic [3:0]  ALU_ADD = 4'b0010;
   localparam logic [3:0]  ALU_NOP = 4'b0000;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

   state_e      state_q, state_d;
   logic [63:0] acc_q, acc_d;
   logic [63:0] mcand_q, mcand_d;
   logic [63:0] mplier_q, mplier_d;
   logic [6:0]  count_q, count_d;
   logic        illegal_q, illegal_d;
   logic [63:0] result_q, result_d;

   logic [63:0] acc_nxt;
   logic [63:0] mplier_sh;
   logic        last;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         count_q   <= '0;
         illegal_q <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         count_q   <= count_d;
         illegal_q <= illegal_d;
         result_q  <= result_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      count_d   = count_q;
      illegal_d = illegal_q;
      result_d  = result_q;
      busy      = 1'b0;
      done      = 1'b0;
      illegal   = 1'b0;
      alu_ctrl  = ALU_NOP;
      // Partial-product step; carries past bit 63 fall off.
      acc_nxt   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
      mplier_sh = mplier_q >> 1;
      last      = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (opcode != OPC_MUL) begin
                  state_d   = DONE;
                  illegal_d = 1'b1;
                  result_d  = '0;
               end
`ifdef MUL_EARLY_EXIT_EN
               else if (op_b == '0) begin
                  state_d   = DONE;
                  illegal_d = 1'b0;
                  result_d  = '0;
               end
`endif
               else begin
                  state_d   = RUN;
                  illegal_d = 1'b0;
                  acc_d     = '0;
                  mcand_d   = op_a;
                  mplier_d  = op_b;
                  count_d   = '0;
               end
            end
         end
         RUN: begin
            busy     = 1'b1;
            alu_ctrl = ALU_ADD;
            acc_d    = acc_nxt;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_sh;
            count_d  = count_q + 7'd1;
            // count_q == 63 means this edge completes iteration 64.
            last     = (count_q == 7'd63);
`ifdef MUL_EARLY_EXIT_EN
            last     = last || (mplier_sh == '0);
`endif
            if (last) begin
               state_d  = DONE;
               result_d = acc_nxt;
            end
         end
         DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            illegal = illegal_q;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign result = result_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: directed self-checking bench for mul_sequencer.
// Expected latencies follow MUL_EARLY_EXIT_EN when it is defined.
module tb_mul_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [10:0] opcode;
   logic [63:0] op_a;
   logic [63:0] op_b;
   logic        busy;
   logic        done;
   logic        illegal;
   logic [63:0] result;
   logic [3:0]  alu_ctrl;

   localparam logic [10:0] MUL = 11'b10011011000;
   localparam logic [10:0] ADD = 11'b10001011000;
`ifdef MUL_EARLY_EXIT_EN
   localparam bit EE = 1'b1;
`else
   localparam bit EE = 1'b0;
`endif

   int errs   = 0;
   int checks = 0;

   mul_sequencer dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .opcode   (opcode),
      .op_a     (op_a),
      .op_b     (op_b),
      .busy     (busy),
      .done     (done),
      .illegal  (illegal),
      .result   (result),
      .alu_ctrl (alu_ctrl)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Start in cycle 0; done expected in cycle exp_len+1.
   // inj > 0 raises a competing start during that cycle.
   task automatic run_op(input string tag, input logic [10:0] opc,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp_res, input logic exp_ill,
                         input int exp_len, input int inj);
      int c;
      int bad;
      bit seen;
      opcode = opc;
      op_a   = a;
      op_b   = b;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      opcode = '0;
      op_a   = '1;
      op_b   = '1;
      seen   = 1'b0;
      bad    = 0;
      for (c = 1; c <= 100; c++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (busy !== 1'b1 || alu_ctrl !== 4'b0010 || illegal !== 1'b0)
            bad++;
         if (c == inj) begin
            opcode = MUL;
            op_a   = 64'd5;
            op_b   = 64'd5;
            start  = 1'b1;
         end
         tick();
         start = 1'b0;
      end
      chk({tag, "_seen"}, 64'(seen), 64'd1);
      chk({tag, "_lat"}, 64'(c), 64'(exp_len + 1));
      chk({tag, "_run"}, 64'(bad), 64'd0);
      chk({tag, "_res"}, result, exp_res);
      chk({tag, "_ill"}, 64'(illegal), 64'(exp_ill));
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      chk({tag, "_alu"}, 64'(alu_ctrl), 64'd0);
      tick();
      chk({tag, "_idle"}, 64'(busy), 64'd0);
      chk({tag, "_done0"}, 64'(done), 64'd0);
      chk({tag, "_ill0"}, 64'(illegal), 64'd0);
      chk({tag, "_hold"}, result, exp_res);
   endtask

   initial begin
      int pulses;
      rst_n  = 1'b0;
      start  = 1'b0;
      opcode = '0;
      op_a   = '0;
      op_b   = '0;
      tick();
      tick();
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_ill", 64'(illegal), 64'd0);
      chk("rst_res", result, 64'd0);
      chk("rst_alu", 64'(alu_ctrl), 64'd0);

      // start while in reset is ignored
      opcode = MUL;
      op_a   = 64'd3;
      op_b   = 64'd5;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      rst_n  = 1'b1;
      chk("rst_start", 64'(busy), 64'd0);
      tick();
      chk("rst_start2", 64'(busy), 64'd0);

      run_op("mul3x5", MUL, 64'd3, 64'd5, 64'd15, 1'b0,
             EE ? 3 : 64, 0);
      run_op("carry", MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
             64'hFFFF_FFFF_FFFF_FFFE, 1'b0, EE ? 2 : 64, 0);
      run_op("illegal", ADD, 64'd3, 64'd5, 64'd0, 1'b1, 0, 0);
      run_op("bzero", MUL, 64'h1234, 64'd0, 64'd0, 1'b0,
             EE ? 0 : 64, 0);
      run_op("ignore", MUL, 64'd3, 64'h8000_0000_0000_0001,
             64'h8000_0000_0000_0003, 1'b0, 64, 10);
      run_op("wide", MUL, 64'h0000_0001_0000_0001,
             64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
             EE ? 32 : 64, 0);

      // reset in cycle 20 aborts the operation
      opcode = MUL;
      op_a   = 64'd3;
      op_b   = 64'h8000_0000_0000_0001;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      repeat (19) tick();
      chk("abort_pre", 64'(busy), 64'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_res", result, 64'd0);
      chk("abort_alu", 64'(alu_ctrl), 64'd0);
      pulses = 0;
      for (int i = 0; i < 80; i++) begin
         if (done) pulses++;
         tick();
      end
      chk("abort_nopulse", 64'(pulses), 64'd0);

      // start in the first cycle after release
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      run_op("postrst", MUL, 64'd7, 64'd9, 64'd63, 1'b0,
             EE ? 4 : 64, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
